gpr_scoreboard: RTL

GPR_SCOREBOARD -- requirements
Module: gpr_scoreboard

---
 rtl/gpr_scoreboard_pkg.sv | 53 +++++
 rtl/gpr_scoreboard_sb_counter.sv | 30 +++
 rtl/gpr_scoreboard.sv | 99 +++++++++
 3 files changed

// File: rtl/gpr_scoreboard_pkg.sv
// Shared definitions for the GPR scoreboard and its neighbours in the ID/WB datapath.
// Holds register-file geometry, in-flight limits and the ID/WB/RF/CSR bundle layouts.
package gpr_scoreboard_pkg;

    localparam int NREG         = 32;
    localparam int REG_IDX_W    = 5;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int TOT_W        = $clog2(MAX_INFLIGHT) + 1;

    localparam int RF_DATA_W    = 32;
    localparam int CSR_ADDR_W   = 14;

    // ID request: rs1, rs1_en, rs2, rs2_en, rd, rd_we, csr, valid, issue
    localparam int ID_REQ_W     = 3 * REG_IDX_W + 6;
    // WB retire: rd, we, valid
    localparam int WB_RET_W     = REG_IDX_W + 2;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic                 rs1_en;
        logic [REG_IDX_W-1:0] rs2;
        logic                 rs2_en;
        logic [REG_IDX_W-1:0] rd;
        logic                 rd_we;
        logic                 csr;
        logic                 valid;
        logic                 issue;
    } id_req_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        logic                 valid;
    } wb_ret_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] addr;
        logic                 we;
        logic [RF_DATA_W-1:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        logic [CSR_ADDR_W-1:0] addr;
        logic                  we;
        logic [RF_DATA_W-1:0]  wdata;
    } csr_req_t;

    function automatic logic is_tracked(input logic [REG_IDX_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/gpr_scoreboard_sb_counter.sv
// Saturating up/down counter: simultaneous inc+dec holds, clr and rst force zero.
// Never wraps in either direction; illegal over/underflow requests are simply ignored.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/gpr_scoreboard.sv
// In-order GPR scoreboard: per-register writer counts, total in-flight count, CSR serialization.
// id_stall is purely combinational from inputs and current state; flush clears all tracking.
module gpr_scoreboard #(
    parameter int NREG         = gpr_scoreboard_pkg::NREG,
    parameter int CNT_W        = gpr_scoreboard_pkg::CNT_W,
    parameter int MAX_INFLIGHT = gpr_scoreboard_pkg::MAX_INFLIGHT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     id_valid,
    input  logic [gpr_scoreboard_pkg::REG_IDX_W-1:0] id_rs1,
    input  logic [gpr_scoreboard_pkg::REG_IDX_W-1:0] id_rs2,
    input  logic                                     id_rs1_en,
    input  logic                                     id_rs2_en,
    input  logic [gpr_scoreboard_pkg::REG_IDX_W-1:0] id_rd,
    input  logic                                     id_rd_we,
    input  logic                                     id_csr,
    input  logic                                     id_issue,
    input  logic                                     wb_valid,
    input  logic [gpr_scoreboard_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic                                     wb_we,
    input  logic                                     flush,
    output logic                                     id_stall,
    output logic [NREG-1:0]                          pending_mask,
    output logic                                     csr_busy
);

    import gpr_scoreboard_pkg::*;

    localparam int              TW      = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [TW-1:0]    w_tot;
    logic [NREG-1:0]  w_mask;
    logic             r_csr_busy;
    logic             w_raw, w_sat, w_cap, w_csr, w_hazard, w_stall, w_issue;

    // A stalled id_issue is a protocol error; it must not touch state.
    assign w_issue = id_issue && !w_stall;

    assign w_cnt[0]  = '0;
    assign w_mask[0] = 1'b0;

    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
        sb_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .i_inc (w_issue && id_rd_we && id_rd == REG_IDX_W'(gi)),
            .i_dec (wb_valid && wb_we && wb_rd == REG_IDX_W'(gi)),
            .i_clr (flush),
            .o_cnt (w_cnt[gi])
        );
        assign w_mask[gi] = (w_cnt[gi] != '0) && !rst;
    end

    sb_counter #(.W(TW)) u_tot (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_issue),
        .i_dec (wb_valid),
        .i_clr (flush),
        .o_cnt (w_tot)
    );

    // While busy, the CSR op is the only thing in flight, so any retire is its retire.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_csr_busy <= 1'b0;
        end else if (w_issue && id_csr) begin
            r_csr_busy <= 1'b1;
        end else if (wb_valid) begin
            r_csr_busy <= 1'b0;
        end
    end

    assign w_raw = (id_rs1_en && w_mask[id_rs1]) || (id_rs2_en && w_mask[id_rs2]);
    assign w_sat = id_rd_we && is_tracked(id_rd) && (w_cnt[id_rd] == CNT_MAX);
    assign w_cap = (w_tot == TW'(MAX_INFLIGHT));
    assign w_csr = (id_csr && w_tot != '0) || r_csr_busy;

    // Gate state-derived terms with rst so outputs are defined before the first edge.
    assign w_hazard = !rst && (w_raw || w_sat || w_cap || w_csr);
    assign w_stall  = id_valid && (w_hazard || flush);

    assign id_stall     = w_stall;
    assign pending_mask = w_mask;
    assign csr_busy     = r_csr_busy && !rst;

    a_issue_legal: assert property (@(posedge clk) disable iff (rst)
        (id_issue && !flush) |-> (id_valid && !w_stall));

    a_wb_nonempty: assert property (@(posedge clk) disable iff (rst)
        (wb_valid && !flush) |-> (w_tot != '0));

    a_wb_cnt_nonzero: assert property (@(posedge clk) disable iff (rst)
        (wb_valid && wb_we && wb_rd != '0 && !flush) |-> (w_cnt[wb_rd] != '0));

endmodule
